// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full subtractor plus a borrow flop.
// Operands stream LSB first; result, borrow and overflow publish with done.

module full_subtractor (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic difference,
    output logic borrow
);

    // Single-bit x - y - bin
    always_comb begin
        difference = x ^ y ^ bin;
        borrow     = (~x & y) | (~(x ^ y) & bin);
    end

endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] d_sh;
    logic             brw;
    logic [CW-1:0]    cnt;
    logic             a_msb;
    logic             b_msb;

    logic             fs_diff;
    logic             fs_borrow;
    logic [WIDTH-1:0] d_next;

    full_subtractor u_fs (
        .x          (a_sh[0]),
        .y          (b_sh[0]),
        .bin        (brw),
        .difference (fs_diff),
        .borrow     (fs_borrow)
    );

    // Difference register as it will look after this bit is shifted in
    always_comb begin
        d_next = {fs_diff, d_sh[WIDTH-1:1]};
    end

    // Controller FSM with registered status and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sh       <= '0;
            b_sh       <= '0;
            d_sh       <= '0;
            brw        <= 1'b0;
            cnt        <= '0;
            a_msb      <= 1'b0;
            b_msb      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        brw   <= bin;
                        cnt   <= '0;
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh <= {1'b0, b_sh[WIDTH-1:1]};
                    d_sh <= d_next;
                    brw  <= fs_borrow;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        diff       <= d_next;
                        borrow_out <= fs_borrow;
                        ovf        <= (a_msb != b_msb) &&
                                      (d_next[WIDTH-1] != a_msb);
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Directed bench for serial_subtractor_ctrl at WIDTH=8.
// Vector table plus hand-written multi-cycle sequences.

module tb_serial_subtractor_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;
    logic       ovf;

    int total;
    int bad;

    serial_subtractor_ctrl #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .bin        (bin),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] va;
        logic [7:0] vb;
        logic       vbin;
        logic [7:0] ed;
        logic       eb;
        logic       eo;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launch one op, then sample each negedge until done or timeout
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic tbin,
                          output int bcnt, output int dcnt);
        @(negedge clk);
        a = ta; b = tb_v; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (busy) bcnt++;
            if (done) begin
                dcnt++;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int bc;
        int dc;
        int k;
        int last;
        int seen;
        logic [7:0] ba [3];
        logic [7:0] bb [3];
        logic [7:0] bd [3];
        logic       bbo [3];
        logic       bov [3];

        total = 0;
        bad   = 0;
        vecs[0] = '{8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b1};
        vecs[8] = '{8'h3C, 8'h0F, 1'b1, 8'h2C, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_borrow", borrow_out, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;

        // Table-driven single operations
        foreach (vecs[i]) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vbin, bc, dc);
            check($sformatf("v%0d_done", i), dc, 1);
            check($sformatf("v%0d_busy_cycles", i), bc, 8);
            check($sformatf("v%0d_diff", i), diff, vecs[i].ed);
            check($sformatf("v%0d_borrow", i), borrow_out, vecs[i].eb);
            check($sformatf("v%0d_ovf", i), ovf, vecs[i].eo);
        end

        // Outputs hold through IDLE
        @(negedge clk);
        @(negedge clk);
        check("hold_done", done, 0);
        check("hold_diff", diff, 8'h2C);

        // Start during RUN cycles 3-5 is ignored
        @(negedge clk);
        a = 8'h5A; b = 8'h23; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i >= 3 && i <= 5) begin
                start = 1'b1; a = 8'hFF; b = 8'h00;
            end else begin
                start = 1'b0;
            end
            if (done) seen++;
            @(negedge clk);
        end
        check("ign_done_count", seen, 1);
        check("ign_diff", diff, 8'h37);
        check("ign_borrow", borrow_out, 0);
        check("ign_busy_after", busy, 0);

        // Back-to-back with start held high
        ba = '{8'h5A, 8'h80, 8'h7F};
        bb = '{8'h23, 8'h01, 8'hFF};
        bd = '{8'h37, 8'h7F, 8'h80};
        bbo = '{1'b0, 1'b0, 1'b1};
        bov = '{1'b0, 1'b1, 1'b1};
        a = ba[0]; b = bb[0]; bin = 1'b0; start = 1'b1;
        k = 0;
        last = 0;
        for (int cyc = 0; cyc < 60 && k < 3; cyc++) begin
            @(negedge clk);
            if (busy == done) begin
                bad++;
                $display("FAIL b2b_busy_vs_done: busy=%0b done=%0b",
                         busy, done);
            end
            if (done) begin
                check($sformatf("b2b%0d_diff", k), diff, bd[k]);
                check($sformatf("b2b%0d_borrow", k), borrow_out, bbo[k]);
                check($sformatf("b2b%0d_ovf", k), ovf, bov[k]);
                if (k > 0)
                    check($sformatf("b2b%0d_period", k), cyc - last, 9);
                last = cyc;
                k++;
                if (k == 3) start = 1'b0;
                else begin
                    a = ba[k]; b = bb[k];
                end
            end
        end
        total++;
        if (k != 3) begin
            bad++;
            $display("FAIL b2b_timeout: got %0d results expected 3", k);
        end
        start = 1'b0;

        // Reset during RUN aborts without done
        @(negedge clk);
        @(negedge clk);
        a = 8'h80; b = 8'h01; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_diff", diff, 0);
        check("abort_borrow", borrow_out, 0);
        check("abort_ovf", ovf, 0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("abort_quiet", seen, 0);
        run_op(8'hC8, 8'h64, 1'b0, bc, dc);
        check("post_done", dc, 1);
        check("post_busy_cycles", bc, 8);
        check("post_diff", diff, 8'h64);
        check("post_ovf", ovf, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
